// File: rtl/cnn_window_gen.sv
// Sliding-window generator for CNN convolution: builds KxK windows from a raster pixel
// stream using K-1 line buffers and per-row column history, with stride 1 or 2.
module cnn_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int CH         = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           stride,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH*DATA_WIDTH-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [K*K*CH*DATA_WIDTH-1:0]   out_window,
  output logic                           out_last,
  output logic                           frame_done
);

  localparam int PIX_W = CH * DATA_WIDTH;
  localparam int WIN_W = K * K * PIX_W;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  // With stride 2 the last qualifying column/row steps back by one when the
  // distance from the first window position to the image edge is odd.
  localparam int COL_LAST2_I = (((IMG_W - K) % 2) == 0) ? IMG_W - 1 : IMG_W - 2;
  localparam int ROW_LAST2_I = (((IMG_H - K) % 2) == 0) ? IMG_H - 1 : IMG_H - 2;
  localparam logic [COL_W-1:0] COL_LAST2 = COL_W'(COL_LAST2_I);
  localparam logic [ROW_W-1:0] ROW_LAST2 = ROW_W'(ROW_LAST2_I);

  // Frame position and per-frame stride
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             stride_lat;

  // Pixel storage: K-1 previous rows, plus K-1 older columns for each window row
  logic [PIX_W-1:0] line_buf [K-1][IMG_W];
  logic [PIX_W-1:0] history  [K][K-1];
  logic [PIX_W-1:0] col_vec  [K];

  logic             accept;
  logic             first_pix;
  logic             last_pix;
  logic             col_hit;
  logic             row_hit;
  logic             complete;
  logic             last_win;
  logic [WIN_W-1:0] window_p0;

  logic             vld_p1;
  logic             last_p1;
  logic             done_p1;
  logic [WIN_W-1:0] win_p1;

  assign in_ready  = out_ready || !vld_p1;
  assign accept    = in_valid && in_ready && !clear;
  assign first_pix = (col == '0) && (row == '0);
  assign last_pix  = (col == COL_MAX) && (row == ROW_MAX);

  // Parity comparison implements the stride-2 modulo test
  assign col_hit  = (col >= COL_FIRST) && (!stride_lat || (col[0] == COL_FIRST[0]));
  assign row_hit  = (row >= ROW_FIRST) && (!stride_lat || (row[0] == ROW_FIRST[0]));
  assign complete = col_hit && row_hit;
  assign last_win = complete
                 && (col == (stride_lat ? COL_LAST2 : COL_MAX))
                 && (row == (stride_lat ? ROW_LAST2 : ROW_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      stride_lat <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (first_pix) begin
        stride_lat <= stride;
      end
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Column of the current image position, oldest row first, live pixel last
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_vec[r] = line_buf[r][col];
    end
    col_vec[K-1] = in_data;
  end

  always_comb begin
    window_p0 = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        window_p0[(r*K+c)*PIX_W +: PIX_W] = history[r][c];
      end
      window_p0[(r*K+K-1)*PIX_W +: PIX_W] = col_vec[r];
    end
  end

  // Storage is never reset: row/column gating keeps stale data out of windows
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 2; c++) begin
          history[r][c] <= history[r][c+1];
        end
        history[r][K-2] <= col_vec[r];
      end
      for (int r = 0; r < K - 2; r++) begin
        line_buf[r][col] <= line_buf[r+1][col];
      end
      line_buf[K-2][col] <= in_data;
    end
  end

  // ---- p0 -> p1: registered output stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
      win_p1  <= '0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      done_p1 <= accept && last_pix;
      if (accept && complete) begin
        win_p1  <= window_p0;
        vld_p1  <= 1'b1;
        last_p1 <= last_win;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_last   = last_p1;
  assign out_window = win_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen on a 5x5 image, K=3, one 8-bit channel.
module tb_cnn_window_gen;
  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int K  = 3;
  localparam int CH = 1;
  localparam int WW = K*K*CH*DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          stride;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
  logic          out_last;
  logic          frame_done;

  always #5 clk = ~clk;

  cnn_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(K), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stride(stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_last(out_last), .frame_done(frame_done)
  );

  typedef struct {
    int   comp;
    logic last;
  } vec_t;

  vec_t s1_tbl[9];
  vec_t s2_tbl[4];

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] win_q[$];
  logic          last_q[$];
  int            tag_q[$];
  int            acc_cnt = 0;
  logic          pend = 1'b0;
  int            fd_cnt = 0;

  // Monitor: windows taken, tagged with the number of pixels accepted so far
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      win_q.push_back(out_window);
      last_q.push_back(out_last);
      tag_q.push_back(acc_cnt + int'(pend));
    end
    acc_cnt <= acc_cnt + int'(pend);
    pend    <= in_valid && in_ready && rst_n;
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] exp_win(input int comp, input int off);
    logic [WW-1:0] w;
    int row, col;
    w = '0;
    row = comp / W;
    col = comp % W;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'(off + W*(row-2+r) + (col-2+c));
    return w;
  endfunction

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pixel %0d in_ready stuck at 0, want 1", v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input bit s2, input int off, input int qbase,
                             input int tagbase, input bit chk_tag);
    vec_t v;
    int n, idx;
    n = s2 ? 4 : 9;
    for (int i = 0; i < n; i++) begin
      v = s2 ? s2_tbl[i] : s1_tbl[i];
      idx = qbase + i;
      if (idx >= win_q.size()) begin
        checks++;
        errors++;
        $display("FAIL missing_window pixel %0d got none want one", v.comp);
      end else begin
        chkw($sformatf("window_p%0d_off%0d", v.comp, off), win_q[idx], exp_win(v.comp, off));
        chki($sformatf("last_p%0d_off%0d", v.comp, off), int'(last_q[idx]), int'(v.last));
        if (chk_tag)
          chki($sformatf("latency_p%0d_off%0d", v.comp, off), tag_q[idx], tagbase + v.comp + 1);
      end
    end
  endtask

  initial begin
    int qb, tb, fdb;
    bit ok_rdy, ok_vld, ok_win;

    s1_tbl = '{'{12, 1'b0}, '{13, 1'b0}, '{14, 1'b0},
               '{17, 1'b0}, '{18, 1'b0}, '{19, 1'b0},
               '{22, 1'b0}, '{23, 1'b0}, '{24, 1'b1}};
    s2_tbl = '{'{12, 1'b0}, '{14, 1'b0}, '{22, 1'b0}, '{24, 1'b1}};

    rst_n = 1'b0; clear = 1'b0; stride = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_out_last", int'(out_last), 0);
    chki("rst_frame_done", int'(frame_done), 0);
    chkw("rst_out_window", out_window, '0);
    chki("rst_in_ready", int'(in_ready), 1);
    align();
    rst_n = 1'b1;
    align();

    // Stride 1 frame with latency and frame_done timing
    qb = win_q.size(); tb = acc_cnt + int'(pend); fdb = fd_cnt;
    for (int p = 0; p < 25; p++) begin
      send(p);
      if (p == 11) chki("no_window_before_p12", int'(out_valid), 0);
      if (p == 12) begin
        chki("valid_after_p12", int'(out_valid), 1);
        chkw("first_window_s1", out_window, exp_win(12, 0));
      end
    end
    chki("last_after_p24", int'(out_last), 1);
    chki("frame_done_after_p24", int'(frame_done), 1);
    settle();
    chki("frame_done_drops", int'(frame_done), 0);
    chki("s1_count", win_q.size() - qb, 9);
    chki("s1_frame_done_pulses", fd_cnt - fdb, 1);
    check_frame(1'b0, 0, qb, tb, 1'b1);
    align();

    // Stride 2 frame
    stride = 1'b1;
    qb = win_q.size(); tb = acc_cnt + int'(pend);
    for (int p = 0; p < 25; p++) send(p);
    settle();
    chki("s2_count", win_q.size() - qb, 4);
    check_frame(1'b1, 0, qb, tb, 1'b1);
    align();

    // Backpressure: hold output for 10 cycles after the first window
    stride = 1'b0;
    qb = win_q.size();
    for (int p = 0; p < 13; p++) send(p);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd13;
    tb = acc_cnt + int'(pend);
    ok_rdy = 1'b1; ok_vld = 1'b1; ok_win = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) ok_rdy = 1'b0;
      if (out_valid !== 1'b1) ok_vld = 1'b0;
      if (out_window !== exp_win(12, 0)) ok_win = 1'b0;
    end
    #1;
    chki("stall_in_ready_low", int'(ok_rdy), 1);
    chki("stall_valid_held", int'(ok_vld), 1);
    chki("stall_window_held", int'(ok_win), 1);
    chki("stall_no_accept", acc_cnt + int'(pend), tb);
    align();
    out_ready = 1'b1;
    for (int p = 13; p < 25; p++) send(p);
    settle();
    chki("stall_count", win_q.size() - qb, 9);
    check_frame(1'b0, 0, qb, 0, 1'b0);
    align();

    // Asynchronous reset mid-frame, then a fresh frame
    for (int p = 0; p < 18; p++) send(p);
    rst_n = 1'b0;
    @(negedge clk);
    chki("midrst_out_valid", int'(out_valid), 0);
    chki("midrst_out_last", int'(out_last), 0);
    chki("midrst_frame_done", int'(frame_done), 0);
    chkw("midrst_out_window", out_window, '0);
    chki("midrst_in_ready", int'(in_ready), 1);
    align();
    rst_n = 1'b1;
    align();
    qb = win_q.size(); tb = acc_cnt + int'(pend);
    for (int p = 0; p < 25; p++) send(30 + p);
    settle();
    chki("postrst_count", win_q.size() - qb, 9);
    check_frame(1'b0, 30, qb, tb, 1'b1);
    align();

    // Back-to-back frames, stride changed mid-frame
    stride = 1'b0;
    qb = win_q.size(); tb = acc_cnt + int'(pend); fdb = fd_cnt;
    for (int p = 0; p < 25; p++) begin
      if (p == 7) stride = 1'b1;
      send(p);
    end
    for (int p = 0; p < 25; p++) send(100 + p);
    settle();
    chki("b2b_count", win_q.size() - qb, 13);
    chki("b2b_frame_done_pulses", fd_cnt - fdb, 2);
    check_frame(1'b0, 0, qb, tb, 1'b1);
    check_frame(1'b1, 100, qb + 9, tb + 25, 1'b1);
    align();

    // Soft clear mid-frame with a pixel offered in the same cycle
    stride = 1'b0;
    for (int p = 0; p < 9; p++) send(p);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd99;
    align();
    clear = 1'b0;
    in_valid = 1'b0;
    chki("clear_out_valid", int'(out_valid), 0);
    qb = win_q.size(); tb = acc_cnt + int'(pend);
    for (int p = 0; p < 25; p++) send(50 + p);
    settle();
    chki("clear_count", win_q.size() - qb, 9);
    check_frame(1'b0, 50, qb, tb, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
